mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 51 +++++
 rtl/mem_wb_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// Bundle of the MEM->WB stage signals: upstream instruction, data-SRAM
// response, pipeline control and the writeback payload. The stage itself
// connects through the slave modport. The environment around it (memory
// stage, SRAM, hazard unit, writeback) connects through the master modport.
interface mem_wb_stage_if;
  // Instruction presented by the memory stage
  logic        mem_valid_i;
  logic        mem_wren_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  mem_ldop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_inst_i;

  // Data SRAM read response
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  // Pipeline control
  logic        wb_stall_i;
  logic        wb_flush_i;
  logic        mem_ready_o;
  logic        stall_req_o;

  // Writeback payload
  logic        wb_valid_o;
  logic        wb_wren_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_inst_o;

  modport slave (
    input  mem_valid_i, mem_wren_i, mem_waddr_i, mem_wdata_i, mem_ldop_i,
           mem_addr_i, mem_pc_i, mem_inst_i,
           data_rvalid_i, data_rdata_i,
           wb_stall_i, wb_flush_i,
    output mem_ready_o, stall_req_o,
           wb_valid_o, wb_wren_o, wb_waddr_o, wb_wdata_o, wb_pc_o, wb_inst_o
  );

  modport master (
    output mem_valid_i, mem_wren_i, mem_waddr_i, mem_wdata_i, mem_ldop_i,
           mem_addr_i, mem_pc_i, mem_inst_i,
           data_rvalid_i, data_rdata_i,
           wb_stall_i, wb_flush_i,
    input  mem_ready_o, stall_req_o,
           wb_valid_o, wb_wren_o, wb_waddr_o, wb_wdata_o, wb_pc_o, wb_inst_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load-data alignment.
// Non-loads pass to writeback one cycle after acceptance. Loads park in WAIT
// until the data SRAM answers, then the aligned, extended result is written
// back. A flush during an outstanding load moves to DRAIN so the orphaned
// response is swallowed instead of being written back.
module mem_wb_stage (
  input  logic               clk,
  input  logic               rst_n,
  mem_wb_stage_if.slave      pipe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  state_t      state;
  logic        wb_valid;
  logic        wren_cap;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic [2:0]  ld_op;
  logic [1:0]  ld_off;

  logic        ready;
  logic        accept;
  logic        is_load;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;

  // Only the byte offset of the effective address matters here
  logic        unused_addr_bits;
  assign unused_addr_bits = ^pipe.mem_addr_i[31:2];

  assign ready   = (state == IDLE) && !pipe.wb_stall_i;
  assign accept  = pipe.mem_valid_i && ready;
  assign is_load = (pipe.mem_ldop_i >= LD_LB) && (pipe.mem_ldop_i <= LD_LW);

  // Pick the addressed byte/half of the returning word and extend it
  always_comb begin
    sel_byte    = pipe.data_rdata_i[7:0];
    sel_half    = ld_off[1] ? pipe.data_rdata_i[31:16] : pipe.data_rdata_i[15:0];
    load_result = pipe.data_rdata_i;
    case (ld_off)
      2'd0:    sel_byte = pipe.data_rdata_i[7:0];
      2'd1:    sel_byte = pipe.data_rdata_i[15:8];
      2'd2:    sel_byte = pipe.data_rdata_i[23:16];
      default: sel_byte = pipe.data_rdata_i[31:24];
    endcase
    case (ld_op)
      LD_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_result = {24'd0, sel_byte};
      LD_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_result = {16'd0, sel_half};
      default: load_result = pipe.data_rdata_i;
    endcase
  end

  // Stage FSM and writeback payload registers; flush beats stall beats new input.
  // DRAIN swallows its response even under stall, otherwise a stalled pipe
  // could miss the only response it is waiting for and never leave DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
      wren_cap <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
      wb_pc    <= 32'd0;
      wb_inst  <= 32'd0;
      ld_op    <= LD_NONE;
      ld_off   <= 2'd0;
    end else if (pipe.wb_flush_i) begin
      wb_valid <= 1'b0;
      if ((state == WAIT) && !pipe.data_rvalid_i) begin
        state <= DRAIN;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wren_cap <= pipe.mem_wren_i;
            wb_waddr <= pipe.mem_waddr_i;
            wb_wdata <= pipe.mem_wdata_i;
            wb_pc    <= pipe.mem_pc_i;
            wb_inst  <= pipe.mem_inst_i;
            ld_off   <= pipe.mem_addr_i[1:0];
            if (is_load) begin
              ld_op    <= pipe.mem_ldop_i;
              wb_valid <= 1'b0;
              state    <= WAIT;
            end else begin
              ld_op    <= LD_NONE;
              wb_valid <= 1'b1;
            end
          end else if (!pipe.wb_stall_i) begin
            wb_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (pipe.data_rvalid_i) begin
            wb_wdata <= load_result;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (pipe.data_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign pipe.mem_ready_o = ready;
  assign pipe.stall_req_o = (state == WAIT);
  assign pipe.wb_valid_o  = wb_valid;
  assign pipe.wb_wren_o   = wb_valid && wren_cap;
  assign pipe.wb_waddr_o  = wb_waddr;
  assign pipe.wb_wdata_o  = wb_wdata;
  assign pipe.wb_pc_o     = wb_pc;
  assign pipe.wb_inst_o   = wb_inst;

endmodule
